// File: rtl/fpf_link_scheduler_pkg.sv
// Shared types for the FPF link scheduler: symbol width, radix and FSM states.
// Optional parity symbol is compiled in with FPF_SCHED_PARITY_EN.
package fpf_sched_pkg;

  localparam int SYM_W = 3;
  localparam int RADIX = 5;

  typedef logic [SYM_W-1:0] digit_t;

`ifdef FPF_SCHED_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_PAR  = 2'd2
  } sched_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1
  } sched_state_t;
`endif

  function automatic longint pow5(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * RADIX;
    end
    return r;
  endfunction

endpackage

// File: rtl/fpf_link_scheduler_if.sv
// Word-side handshake, link enable and symbol-side outputs of the FPF link scheduler.
interface fpf_link_scheduler_if #(
  parameter int DATA_W = 8
) ();
  import fpf_sched_pkg::*;

  logic              link_en;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  digit_t            sym_data;
  logic              sym_valid;
  logic              sym_first;
  logic              sym_last;
  logic              busy;

  modport master (
    output link_en, in_valid, in_data,
    input  in_ready, sym_data, sym_valid, sym_first, sym_last, busy
  );

  modport slave (
    input  link_en, in_valid, in_data,
    output in_ready, sym_data, sym_valid, sym_first, sym_last, busy
  );
endinterface

// File: rtl/fpf_link_scheduler_div5.sv
// Combinational divide-by-5 used to peel one radix-5 digit off the remaining quotient.
module fpf_div5
  import fpf_sched_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_dividend,
  output logic [DATA_W-1:0] o_quot,
  output digit_t            o_rem
);

  assign o_quot = i_dividend / DATA_W'(RADIX);
  assign o_rem  = SYM_W'(i_dividend % DATA_W'(RADIX));

endmodule

// File: rtl/fpf_link_scheduler.sv
// Radix-5 symbol scheduler feeding the 3-TSV FPF encoder, LSD first, with frame markers.
// Define FPF_SCHED_PARITY_EN to append a sum-of-digits mod 5 parity symbol to each frame.
module fpf_link_scheduler
  import fpf_sched_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  fpf_link_scheduler_if.slave   bus
);

  localparam int CNT_W = $clog2(DIGITS + 1);

  if (pow5(DIGITS) < (longint'(1) << DATA_W)) begin : g_digitsTooFew
    $error("DIGITS radix-5 symbols cannot represent every DATA_W-bit word");
  end

  sched_state_t      r_state;
  sched_state_t      w_nextState;
  logic [DATA_W-1:0] r_quot;
  logic [DATA_W-1:0] w_quot;
  digit_t            w_rem;
  logic [CNT_W-1:0]  r_digitCnt;
  logic              w_lastDigit;
  logic              w_finalCycle;
  logic              w_ready;
  logic              w_accept;
  digit_t            r_symData;
  digit_t            w_symData;
  logic              r_symValid;
  logic              w_symValid;
  logic              r_symFirst;
  logic              w_symFirst;
  logic              r_symLast;
  logic              w_symLast;

  fpf_div5 #(.DATA_W(DATA_W)) u_div5 (
    .i_dividend (r_quot),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  assign w_lastDigit = (r_state == ST_SEND) && (r_digitCnt == CNT_W'(DIGITS - 1));

`ifdef FPF_SCHED_PARITY_EN
  digit_t          r_acc;
  logic [SYM_W:0]  w_accSum;
  digit_t          w_accNext;

  assign w_accSum  = {1'b0, r_acc} + {1'b0, w_rem};
  assign w_accNext = (w_accSum >= (SYM_W+1)'(RADIX)) ? SYM_W'(w_accSum - (SYM_W+1)'(RADIX))
                                                      : SYM_W'(w_accSum);
  assign w_finalCycle = (r_state == ST_PAR);
`else
  assign w_finalCycle = w_lastDigit;
`endif

  // Reset gating keeps in_ready low while reset_n is held, even though IDLE is already loaded.
  assign w_ready  = reset_n && bus.link_en && ((r_state == ST_IDLE) || w_finalCycle);
  assign w_accept = bus.in_valid && w_ready;

  assign bus.in_ready  = w_ready;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.sym_data  = r_symData;
  assign bus.sym_valid = r_symValid;
  assign bus.sym_first = r_symFirst;
  assign bus.sym_last  = r_symLast;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_symData   = '0;
    w_symValid  = 1'b0;
    w_symFirst  = 1'b0;
    w_symLast   = 1'b0;
    if (bus.link_en) begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_nextState = ST_SEND;
          end
        end
        ST_SEND: begin
          w_symValid = 1'b1;
          w_symData  = w_rem;
          w_symFirst = (r_digitCnt == '0);
`ifdef FPF_SCHED_PARITY_EN
          if (w_lastDigit) begin
            w_nextState = ST_PAR;
          end
`else
          w_symLast = w_lastDigit;
          if (w_lastDigit) begin
            w_nextState = w_accept ? ST_SEND : ST_IDLE;
          end
`endif
        end
`ifdef FPF_SCHED_PARITY_EN
        ST_PAR: begin
          w_symValid  = 1'b1;
          w_symData   = r_acc;
          w_symLast   = 1'b1;
          w_nextState = w_accept ? ST_SEND : ST_IDLE;
        end
`endif
        default: begin
          w_nextState = ST_IDLE;
        end
      endcase
    end
  end

  // A new word on the final-symbol cycle overrides the digit step, giving gapless frames.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_quot     <= '0;
      r_digitCnt <= '0;
      r_symData  <= '0;
      r_symValid <= 1'b0;
      r_symFirst <= 1'b0;
      r_symLast  <= 1'b0;
`ifdef FPF_SCHED_PARITY_EN
      r_acc      <= '0;
`endif
    end else begin
      r_symData  <= w_symData;
      r_symValid <= w_symValid;
      r_symFirst <= w_symFirst;
      r_symLast  <= w_symLast;
      if (w_accept) begin
        r_quot     <= bus.in_data;
        r_digitCnt <= '0;
`ifdef FPF_SCHED_PARITY_EN
        r_acc      <= '0;
`endif
      end else if (bus.link_en && (r_state == ST_SEND)) begin
        r_quot     <= w_quot;
        r_digitCnt <= r_digitCnt + CNT_W'(1);
`ifdef FPF_SCHED_PARITY_EN
        r_acc      <= w_accNext;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fpf_link_scheduler.sv
// Randomized self-checking bench for fpf_link_scheduler with a frame-queue reference model.
// Honours FPF_SCHED_PARITY_EN so the expected frames match the compiled configuration.
module tb_fpf_link_scheduler;

  localparam int DATA_W = 8;
  localparam int DIGITS = 4;
`ifdef FPF_SCHED_PARITY_EN
  localparam int FL = DIGITS + 1;
  int lit137[FL]   = '{2, 2, 0, 1, 0};
  int litB2B[2*FL] = '{0, 1, 0, 2, 3, 0, 0, 0, 0, 0};
`else
  localparam int FL = DIGITS;
  int lit137[FL]   = '{2, 2, 0, 1};
  int litB2B[2*FL] = '{0, 1, 0, 2, 0, 0, 0, 0};
`endif

  logic clock;
  logic reset_n;

  fpf_link_scheduler_if #(.DATA_W(DATA_W)) bus ();

  fpf_link_scheduler #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nChecks;
  int nPass;
  int pend[$];
  int frameBuf[$];
  int sentWords[$];
  int gotSyms[$];
  int emitIdx;
  int wordsSent;
  int rxWord;
  int rxPos;
  int rxSum;
  int rxScale;

  task automatic checkOutput(input string name, input int got, input int want);
    nChecks++;
    if (got == want) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // The frame for a word is its radix-5 digits, LSD first, plus the digit-sum parity when built in.
  task automatic buildFrame(input int w);
    int rest;
    int sum;
    frameBuf.delete();
    rest = w;
    sum  = 0;
    for (int k = 0; k < DIGITS; k++) begin
      frameBuf.push_back(rest % 5);
      sum  = sum + (rest % 5);
      rest = rest / 5;
    end
`ifdef FPF_SCHED_PARITY_EN
    frameBuf.push_back(sum % 5);
`endif
  endtask

  task automatic resetModel();
    pend.delete();
    sentWords.delete();
    emitIdx = 0;
    rxWord  = 0;
    rxPos   = 0;
    rxSum   = 0;
    rxScale = 1;
  endtask

  // One clock cycle: drive at the falling edge, check in_ready, advance the model, check after the rising edge.
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic en);
    logic expReady;
    logic accepted;
    logic expV;
    logic expF;
    logic expL;
    int   expD;
    int   sym;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.link_en  = en;
    #1;
    expReady = en && (pend.size() <= 1);
    checkOutput("in_ready", int'(bus.in_ready), int'(expReady));
    accepted = v && expReady;
    expV = 1'b0;
    expF = 1'b0;
    expL = 1'b0;
    expD = 0;
    if (en && (pend.size() > 0)) begin
      expV = 1'b1;
      expD = pend.pop_front();
      expF = (emitIdx == 0);
      expL = (pend.size() == 0);
      emitIdx++;
    end
    if (accepted) begin
      buildFrame(int'(d));
      pend = frameBuf;
      emitIdx = 0;
      sentWords.push_back(int'(d));
      wordsSent++;
    end
    @(posedge clock);
    #1;
    checkOutput("sym_valid", int'(bus.sym_valid), int'(expV));
    checkOutput("sym_data", int'(bus.sym_data), expD);
    checkOutput("sym_first", int'(bus.sym_first), int'(expF));
    checkOutput("sym_last", int'(bus.sym_last), int'(expL));
    checkOutput("busy", int'(bus.busy), int'(pend.size() > 0));
    if (bus.sym_valid) begin
      sym = int'(bus.sym_data);
      gotSyms.push_back(sym);
      checkOutput("sym_range", int'(sym <= 4), 1);
      if (bus.sym_first) begin
        rxWord  = 0;
        rxPos   = 0;
        rxSum   = 0;
        rxScale = 1;
      end
      if (rxPos < DIGITS) begin
        rxWord  = rxWord + sym * rxScale;
        rxScale = rxScale * 5;
        rxSum   = rxSum + sym;
      end else begin
        checkOutput("rx_parity", sym, rxSum % 5);
      end
      rxPos++;
      if (bus.sym_last) begin
        if (sentWords.size() == 0) begin
          checkOutput("rx_unexpected_frame", rxWord, -1);
        end else begin
          checkOutput("rx_word", rxWord, sentWords.pop_front());
        end
      end
    end
    @(negedge clock);
  endtask

  initial begin
    int guard;
    nChecks      = 0;
    nPass        = 0;
    wordsSent    = 0;
    reset_n      = 1'b0;
    bus.link_en  = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    resetModel();

    repeat (2) @(negedge clock);
    #1;
    checkOutput("reset_in_ready", int'(bus.in_ready), 0);
    checkOutput("reset_sym_valid", int'(bus.sym_valid), 0);
    checkOutput("reset_sym_data", int'(bus.sym_data), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkOutput("release_in_ready", int'(bus.in_ready), 1);

    $display("[TB] directed: word 137");
    buildFrame(137);
    checkOutput("model_frame_len", frameBuf.size(), FL);
    for (int i = 0; i < FL && i < frameBuf.size(); i++) begin
      checkOutput("model_frame_137", frameBuf[i], lit137[i]);
    end
    gotSyms.delete();
    applyStimulus(1'b1, 8'd137, 1'b1);
    repeat (FL + 2) applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("w137_count", gotSyms.size(), FL);
    for (int i = 0; i < FL && i < gotSyms.size(); i++) begin
      checkOutput("w137_sym", gotSyms[i], lit137[i]);
    end

    $display("[TB] directed: 255 then 0 back-to-back");
    gotSyms.delete();
    applyStimulus(1'b1, 8'd255, 1'b1);
    guard = 0;
    while (pend.size() > 1 && guard < 20) begin
      applyStimulus(1'b0, 8'd0, 1'b1);
      guard++;
    end
    applyStimulus(1'b1, 8'd0, 1'b1);
    repeat (FL + 2) applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("b2b_count", gotSyms.size(), 2 * FL);
    for (int i = 0; i < 2 * FL && i < gotSyms.size(); i++) begin
      checkOutput("b2b_sym", gotSyms[i], litB2B[i]);
    end

    $display("[TB] directed: link_en gap after digit0");
    gotSyms.delete();
    applyStimulus(1'b1, 8'd137, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0);
    repeat (FL + 2) applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("gap_count", gotSyms.size(), FL);
    for (int i = 0; i < FL && i < gotSyms.size(); i++) begin
      checkOutput("gap_sym", gotSyms[i], lit137[i]);
    end

    $display("[TB] directed: reset mid-frame");
    applyStimulus(1'b1, 8'd137, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_sym_valid", int'(bus.sym_valid), 0);
    checkOutput("midrst_sym_data", int'(bus.sym_data), 0);
    checkOutput("midrst_sym_first", int'(bus.sym_first), 0);
    checkOutput("midrst_sym_last", int'(bus.sym_last), 0);
    checkOutput("midrst_busy", int'(bus.busy), 0);
    checkOutput("midrst_in_ready", int'(bus.in_ready), 0);
    resetModel();
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkOutput("midrst_release_ready", int'(bus.in_ready), 1);
    gotSyms.delete();
    repeat (FL + 2) applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("midrst_no_residual", gotSyms.size(), 0);

    $display("[TB] random: 1000 words");
    wordsSent = 0;
    guard = 0;
    while (wordsSent < 1000 && guard < 20000) begin
      applyStimulus(($urandom_range(0, 3) != 0), DATA_W'($urandom_range(0, 255)),
                    ($urandom_range(0, 7) != 0));
      guard++;
    end
    checkOutput("random_words_sent", int'(wordsSent >= 1000), 1);
    repeat (2 * FL + 2) applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("random_all_reassembled", sentWords.size(), 0);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
